jelly_wishbone_arbiter: RTL and testbench
=========================================

# jelly_wishbone_arbiter

Round-robin arbiter that shares one WISHBONE slave bus, for example a WISHBONE register file behind an AXI4-Lite bridge, between NUM_MASTERS requesters. It grants one master at a time and holds the grant until the slave acks or the master withdraws. A watchdog terminates hung transfers. It sits between the bus masters (bridges, DMA cores, CPUs) and the shared peripheral bus.

## Interface
- NUM_MASTERS, 4: number of requesting masters, 2 to 16.
- WB_ADR_WIDTH, 30: address width.
- WB_DAT_WIDTH, 32: data width.
- WB_SEL_WIDTH, WB_DAT_WIDTH/8: byte-select width.
- TIMEOUT, 255: number of BUSY cycles without ack before forced termination. 0 disables the watchdog.
- GW, clog2(NUM_MASTERS) (min 1): width of the grant index.

Ports:
- reset  in  1  asynchronous, active-high
- clk  in  1  the only clock
- s_wb_adr_i  in  NUM_MASTERS*WB_ADR_WIDTH  per-master address; master i occupies slice i
- s_wb_dat_i  in  NUM_MASTERS*WB_DAT_WIDTH  per-master write data
- s_wb_dat_o  out  WB_DAT_WIDTH  read data, shared by all masters
- s_wb_we_i  in  NUM_MASTERS  write enables
- s_wb_sel_i  in  NUM_MASTERS*WB_SEL_WIDTH  byte selects
- s_wb_stb_i  in  NUM_MASTERS  strobes
- s_wb_ack_o  out  NUM_MASTERS  acks, one-hot or zero
- m_wb_adr_o / m_wb_dat_o / m_wb_we_o / m_wb_sel_o  out  widths as above  granted master's signals
- m_wb_dat_i  in  WB_DAT_WIDTH  slave read data
- m_wb_stb_o  out  1  slave strobe
- m_wb_ack_i  in  1  slave ack
- grant_valid  out  1  arbiter is in BUSY
- grant_index  out  GW  index of the current or most recent grant
- timeout  out  1  one-cycle pulse when the watchdog fires

## Operation
- State machine: IDLE and BUSY.
- IDLE:
  - If any s_wb_stb_i bit is set, pick a master by rotating priority: the search starts at last_grant+1 mod NUM_MASTERS.
  - Load the winner into grant_index and go to BUSY next cycle.
  - With no request, stay in IDLE.
- BUSY:
  - m_wb_adr_o, m_wb_dat_o, m_wb_we_o and m_wb_sel_o are muxed from slice grant_index. These outputs are combinational from the grant register.
  - m_wb_stb_o = s_wb_stb_i[grant_index].
- Normal completion: when m_wb_ack_i & m_wb_stb_o, then in the same cycle s_wb_ack_o[grant_index]=1 and s_wb_dat_o=m_wb_dat_i. Next state is IDLE and last_grant takes grant_index.
- Abort: the granted master drops its stb in BUSY without an ack. Go to IDLE next cycle with no ack. last_grant is still updated.
- Watchdog:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - It fires when the counter equals TIMEOUT-1 with no ack that cycle. The fire asserts s_wb_ack_o[grant_index]=1 with s_wb_dat_o=0, pulses timeout, and goes to IDLE.
  - A real ack in the same cycle wins: timeout stays 0.
- m_wb_ack_i while m_wb_stb_o=0 is ignored.
- The ack of a non-granted master is always 0.
- s_wb_dat_o is 0 whenever no ack is asserted.

## Timing
- Reset values: state IDLE, m_wb_stb_o=0, s_wb_ack_o=0, s_wb_dat_o=0, grant_valid=0, grant_index=0, timeout=0, watchdog counter 0. last_grant=NUM_MASTERS-1, so master 0 has highest priority first.
- Reset asserted mid-transfer: the outputs above take their reset values immediately (asynchronous). No ack is issued for the interrupted transfer.
- Arbitration latency: strobe seen in IDLE at cycle t gives m_wb_stb_o=1 at t+1.
- Zero-wait slave (ack at t+1): s_wb_ack_o at t+1, IDLE at t+2.
- Each transfer occupies at least 2 cycles, which guarantees one IDLE arbitration cycle between grants.
- No combinational path from m_wb_ack_i to m_wb_stb_o. The ack path m_wb_ack_i -> s_wb_ack_o is combinational.
- Fairness: with every master requesting continuously, grants rotate 0,1,...,N-1,0. Any master waits at most N-1 transfers.
- Watchdog fires on BUSY cycle TIMEOUT, counting the entry cycle as 1. Total cycles from request to forced ack: TIMEOUT+1.

## Test plan
- Single master: master 2 writes adr=0x10, dat=0xDEADBEEF, sel=0xF; slave acks 1 cycle after stb. Required: m_wb_* carry those values, s_wb_ack_o=4'b0100 for one cycle, grant_index=2.
- Read: master 1 reads; slave returns 0x12345678 with ack after 3 wait cycles. Required: s_wb_dat_o=0x12345678 in the ack cycle only, and 0 otherwise.
- Round-robin: all 4 masters request continuously out of reset. Required grant sequence 0,1,2,3,0,1; each stb phase followed by exactly 1 IDLE cycle.
- Watchdog: TIMEOUT=8, slave never acks. Required: ack to the granted master and a timeout pulse on the 8th BUSY cycle, s_wb_dat_o=0, then the next master is granted. Second case: ack arrives on the 8th BUSY cycle, so timeout stays 0.
- Abort: master 3 granted, drops stb after 2 cycles. Required: no s_wb_ack_o, IDLE next cycle, then master 0 is granted if requesting.
- Reset mid-transfer: assert reset while BUSY. Required: m_wb_stb_o and grant_valid go low in the same cycle. After release, the first grant goes to master 0.

Source files
------------

// File: rtl/jelly_wishbone_arbiter.sv
// Round-robin arbiter that shares one WISHBONE slave between NUM_MASTERS masters.
// Grants are held until slave ack, master withdrawal, or the watchdog firing.
module jelly_wishbone_arbiter #(
  parameter int NUM_MASTERS  = 4,
  parameter int WB_ADR_WIDTH = 30,
  parameter int WB_DAT_WIDTH = 32,
  parameter int WB_SEL_WIDTH = WB_DAT_WIDTH / 8,
  parameter int TIMEOUT      = 255,
  parameter int GW           = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                                 reset,
  input  logic                                 clk,
  input  logic [NUM_MASTERS*WB_ADR_WIDTH-1:0]  s_wb_adr_i,
  input  logic [NUM_MASTERS*WB_DAT_WIDTH-1:0]  s_wb_dat_i,
  output logic [WB_DAT_WIDTH-1:0]              s_wb_dat_o,
  input  logic [NUM_MASTERS-1:0]               s_wb_we_i,
  input  logic [NUM_MASTERS*WB_SEL_WIDTH-1:0]  s_wb_sel_i,
  input  logic [NUM_MASTERS-1:0]               s_wb_stb_i,
  output logic [NUM_MASTERS-1:0]               s_wb_ack_o,
  output logic [WB_ADR_WIDTH-1:0]              m_wb_adr_o,
  output logic [WB_DAT_WIDTH-1:0]              m_wb_dat_o,
  output logic                                 m_wb_we_o,
  output logic [WB_SEL_WIDTH-1:0]              m_wb_sel_o,
  input  logic [WB_DAT_WIDTH-1:0]              m_wb_dat_i,
  output logic                                 m_wb_stb_o,
  input  logic                                 m_wb_ack_i,
  output logic                                 grant_valid,
  output logic [GW-1:0]                        grant_index,
  output logic                                 timeout
);

  localparam int          CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit          WD_EN   = (TIMEOUT != 0);
  localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t          state;
  state_t          state_next;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   grant_next;
  logic [GW-1:0]   cand;
  logic            req_any;
  logic [CW-1:0]   wd_cnt;
  logic            busy;
  logic            sel_stb;
  logic            bus_stb;
  logic            ack_hit;
  logic            wd_fire;
  logic            done;

  // Rotating priority: scan from the highest index down so the entry right
  // after last_grant is written last and therefore wins.
  always_comb begin
    grant_next = grant_index;
    cand       = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      cand = GW'((int'(last_grant) + 1 + k) % NUM_MASTERS);
      if (s_wb_stb_i[cand]) begin
        grant_next = cand;
      end
    end
  end

  assign req_any = |s_wb_stb_i;
  assign busy    = (state == ST_BUSY);
  assign sel_stb = s_wb_stb_i[grant_index];
  assign bus_stb = busy & sel_stb;
  assign ack_hit = bus_stb & m_wb_ack_i;
  // A real ack in the firing cycle takes precedence over the watchdog.
  assign wd_fire = WD_EN & bus_stb & ~m_wb_ack_i & (wd_cnt == WD_LAST);
  assign done    = busy & (ack_hit | wd_fire | ~sel_stb);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (req_any) state_next = ST_BUSY;
      ST_BUSY: if (done)    state_next = ST_IDLE;
      default:              state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    m_wb_adr_o  = s_wb_adr_i[grant_index*WB_ADR_WIDTH +: WB_ADR_WIDTH];
    m_wb_dat_o  = s_wb_dat_i[grant_index*WB_DAT_WIDTH +: WB_DAT_WIDTH];
    m_wb_sel_o  = s_wb_sel_i[grant_index*WB_SEL_WIDTH +: WB_SEL_WIDTH];
    m_wb_we_o   = s_wb_we_i[grant_index];
    m_wb_stb_o  = bus_stb;
    grant_valid = busy;
    timeout     = wd_fire;
    s_wb_ack_o  = '0;
    if (ack_hit || wd_fire) begin
      s_wb_ack_o[grant_index] = 1'b1;
    end
    s_wb_dat_o  = ack_hit ? m_wb_dat_i : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_index <= '0;
      last_grant  <= GW'(NUM_MASTERS - 1);
      wd_cnt      <= '0;
    end else begin
      if (!busy && req_any) begin
        grant_index <= grant_next;
      end
      if (done) begin
        last_grant <= grant_index;
      end
      // Cleared throughout IDLE so the entry cycle into BUSY counts as zero.
      if (busy) begin
        wd_cnt <= wd_cnt + 1'b1;
      end else begin
        wd_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_jelly_wishbone_arbiter.sv
// Scoreboard bench for jelly_wishbone_arbiter: stimulus pushes expected acks,
// a monitor pops and compares them whenever an ack or timeout appears.
module tb_jelly_wishbone_arbiter;

  localparam int N  = 4;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 8;
  localparam int GW = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N*AW-1:0]   s_wb_adr_i = '0;
  logic [N*DW-1:0]   s_wb_dat_i = '0;
  logic [DW-1:0]     s_wb_dat_o;
  logic [N-1:0]      s_wb_we_i = '0;
  logic [N*SW-1:0]   s_wb_sel_i = '0;
  logic [N-1:0]      s_wb_stb_i = '0;
  logic [N-1:0]      s_wb_ack_o;
  logic [AW-1:0]     m_wb_adr_o;
  logic [DW-1:0]     m_wb_dat_o;
  logic              m_wb_we_o;
  logic [SW-1:0]     m_wb_sel_o;
  logic [DW-1:0]     m_wb_dat_i = '0;
  logic              m_wb_stb_o;
  logic              m_wb_ack_i;
  logic              grant_valid;
  logic [GW-1:0]     grant_index;
  logic              timeout;

  jelly_wishbone_arbiter #(
    .NUM_MASTERS (N),
    .WB_ADR_WIDTH(AW),
    .WB_DAT_WIDTH(DW),
    .WB_SEL_WIDTH(SW),
    .TIMEOUT     (TO),
    .GW          (GW)
  ) dut (
    .reset      (reset),
    .clk        (clk),
    .s_wb_adr_i (s_wb_adr_i),
    .s_wb_dat_i (s_wb_dat_i),
    .s_wb_dat_o (s_wb_dat_o),
    .s_wb_we_i  (s_wb_we_i),
    .s_wb_sel_i (s_wb_sel_i),
    .s_wb_stb_i (s_wb_stb_i),
    .s_wb_ack_o (s_wb_ack_o),
    .m_wb_adr_o (m_wb_adr_o),
    .m_wb_dat_o (m_wb_dat_o),
    .m_wb_we_o  (m_wb_we_o),
    .m_wb_sel_o (m_wb_sel_o),
    .m_wb_dat_i (m_wb_dat_i),
    .m_wb_stb_o (m_wb_stb_o),
    .m_wb_ack_i (m_wb_ack_i),
    .grant_valid(grant_valid),
    .grant_index(grant_index),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [N-1:0]  ack;
    logic [DW-1:0] dat;
    logic          to;
    logic [GW-1:0] gi;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdat;
    logic          we;
    logic [SW-1:0] sel;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Slave model: acks after slave_lat wait cycles; force_ack drives ack regardless of stb.
  int   slave_lat = 0;
  bit   slave_en  = 1'b1;
  bit   force_ack = 1'b0;
  int   wait_cnt  = 0;

  assign m_wb_ack_i = (m_wb_stb_o && slave_en && (wait_cnt == slave_lat)) || force_ack;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_wb_stb_o && !m_wb_ack_i) wait_cnt <= wait_cnt + 1;
    else                           wait_cnt <= 0;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic set_master(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic w, input logic [SW-1:0] s);
    s_wb_adr_i[m*AW +: AW] = a;
    s_wb_dat_i[m*DW +: DW] = d;
    s_wb_sel_i[m*SW +: SW] = s;
    s_wb_we_i[m]           = w;
  endtask

  task automatic expect_ack(input int c, input int m, input logic [DW-1:0] d, input logic to);
    exp_t e;
    e.cyc  = c;
    e.ack  = N'(1) << m;
    e.dat  = d;
    e.to   = to;
    e.gi   = GW'(m);
    e.adr  = s_wb_adr_i[m*AW +: AW];
    e.wdat = s_wb_dat_i[m*DW +: DW];
    e.we   = s_wb_we_i[m];
    e.sel  = s_wb_sel_i[m*SW +: SW];
    sbq.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Monitor: samples 2 time units after each falling edge.
  always @(negedge clk) begin
    #2;
    if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      mon_e = sbq.pop_front();
      chk("missed_ack_cycle", 64'(cyc), 64'(mon_e.cyc));
    end
    if (s_wb_ack_o != '0 || timeout) begin
      if (sbq.size() == 0) begin
        chk("unexpected_ack", 64'({timeout, s_wb_ack_o}), 64'(0));
      end else begin
        mon_e = sbq.pop_front();
        chk("ack_cycle",   64'(cyc),         64'(mon_e.cyc));
        chk("ack_vector",  64'(s_wb_ack_o),  64'(mon_e.ack));
        chk("ack_rdata",   64'(s_wb_dat_o),  64'(mon_e.dat));
        chk("ack_timeout", 64'(timeout),     64'(mon_e.to));
        chk("ack_grant",   64'(grant_index), 64'(mon_e.gi));
        chk("ack_m_adr",   64'(m_wb_adr_o),  64'(mon_e.adr));
        chk("ack_m_dat",   64'(m_wb_dat_o),  64'(mon_e.wdat));
        chk("ack_m_we",    64'(m_wb_we_o),   64'(mon_e.we));
        chk("ack_m_sel",   64'(m_wb_sel_o),  64'(mon_e.sel));
      end
    end else begin
      chk("dat_idle", 64'(s_wb_dat_o), 64'(0));
    end
  end

  initial begin
    int c0;

    // Reset state
    reset = 1'b1;
    repeat (2) tick();
    #1;
    chk("rst_m_stb",   64'(m_wb_stb_o),  64'(0));
    chk("rst_ack",     64'(s_wb_ack_o),  64'(0));
    chk("rst_dat",     64'(s_wb_dat_o),  64'(0));
    chk("rst_gvalid",  64'(grant_valid), 64'(0));
    chk("rst_gindex",  64'(grant_index), 64'(0));
    chk("rst_timeout", 64'(timeout),     64'(0));
    tick();
    reset = 1'b0;
    tick();

    // Single master 2 write, zero-wait slave
    set_master(2, 30'h10, 32'hDEADBEEF, 1'b1, 4'hF);
    m_wb_dat_i = 32'hA5A5_0001;
    slave_en   = 1'b1;
    slave_lat  = 0;
    c0 = cyc;
    s_wb_stb_i = 4'b0100;
    expect_ack(c0 + 1, 2, 32'hA5A5_0001, 1'b0);
    tick();
    #1;
    chk("wr_latency_stb", 64'(m_wb_stb_o),  64'(1));
    chk("wr_gvalid",      64'(grant_valid), 64'(1));
    chk("wr_gindex",      64'(grant_index), 64'(2));
    tick();
    s_wb_stb_i = '0;
    #1;
    chk("wr_idle_after", 64'(grant_valid), 64'(0));
    tick();

    // Read by master 1 with three wait cycles
    set_master(1, 30'h20, 32'h0, 1'b0, 4'hF);
    m_wb_dat_i = 32'h12345678;
    slave_lat  = 3;
    c0 = cyc;
    s_wb_stb_i = 4'b0010;
    expect_ack(c0 + 4, 1, 32'h12345678, 1'b0);
    repeat (3) tick();
    #1;
    chk("rd_wait_gvalid", 64'(grant_valid), 64'(1));
    repeat (2) tick();
    s_wb_stb_i = '0;
    tick();

    // Reset asserted mid-transfer
    set_master(3, 30'h30, 32'h33, 1'b1, 4'h3);
    slave_en = 1'b0;
    c0 = cyc;
    s_wb_stb_i = 4'b1000;
    repeat (2) tick();
    #1;
    chk("midrst_busy_stb", 64'(m_wb_stb_o),  64'(1));
    chk("midrst_busy_gi",  64'(grant_index), 64'(3));
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_stb",    64'(m_wb_stb_o),  64'(0));
    chk("midrst_gvalid", 64'(grant_valid), 64'(0));
    chk("midrst_gindex", 64'(grant_index), 64'(0));
    s_wb_stb_i = '0;
    repeat (2) tick();
    reset     = 1'b0;
    slave_en  = 1'b1;
    slave_lat = 0;

    // Round-robin out of reset with all masters requesting
    for (int i = 0; i < N; i++) begin
      set_master(i, AW'(32'h100 + i), DW'(32'h1000 + i), i[0], SW'(i + 1));
    end
    m_wb_dat_i = 32'h5555AAAA;
    c0 = cyc;
    s_wb_stb_i = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      expect_ack(c0 + 1 + 2 * k, k % N, 32'h5555AAAA, 1'b0);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      #1;
      chk("rr_gindex", 64'(grant_index), 64'(k % N));
      chk("rr_busy",   64'(grant_valid), 64'(1));
      tick();
      #1;
      chk("rr_idle",   64'(grant_valid), 64'(0));
    end
    s_wb_stb_i = '0;
    tick();

    // Watchdog: master 2 hangs, then master 3 acked exactly on the watchdog cycle
    set_master(2, 30'h40, 32'h44, 1'b1, 4'hF);
    set_master(3, 30'h50, 32'h55, 1'b0, 4'h1);
    m_wb_dat_i = 32'hFFFF0000;
    slave_en   = 1'b0;
    c0 = cyc;
    s_wb_stb_i = 4'b1100;
    expect_ack(c0 + 8, 2, 32'h0, 1'b1);
    repeat (7) tick();
    #1;
    chk("wd_no_early_fire", 64'(timeout), 64'(0));
    tick();
    #1;
    chk("wd_fire_gvalid", 64'(grant_valid), 64'(1));
    tick();
    s_wb_stb_i = 4'b1000;
    slave_en   = 1'b1;
    slave_lat  = 7;
    expect_ack(c0 + 17, 3, 32'hFFFF0000, 1'b0);
    #1;
    chk("wd_idle_after", 64'(grant_valid), 64'(0));
    repeat (8) tick();
    #1;
    chk("wd_ack_wins", 64'(timeout), 64'(0));
    tick();
    s_wb_stb_i = '0;
    tick();

    // Abort: master 3 withdraws, stray slave ack ignored, master 0 granted next
    set_master(3, 30'h60, 32'h66, 1'b1, 4'hC);
    set_master(0, 30'h70, 32'h77, 1'b1, 4'hF);
    slave_en = 1'b0;
    c0 = cyc;
    s_wb_stb_i = 4'b1000;
    repeat (3) tick();
    s_wb_stb_i = 4'b0001;
    force_ack  = 1'b1;
    slave_en   = 1'b1;
    slave_lat  = 0;
    expect_ack(c0 + 5, 0, 32'hFFFF0000, 1'b0);
    #1;
    chk("abort_gvalid", 64'(grant_valid), 64'(1));
    chk("abort_stb",    64'(m_wb_stb_o),  64'(0));
    chk("abort_no_ack", 64'(s_wb_ack_o),  64'(0));
    tick();
    force_ack = 1'b0;
    #1;
    chk("abort_idle", 64'(grant_valid), 64'(0));
    tick();
    #1;
    chk("abort_next_gi", 64'(grant_index), 64'(0));
    tick();
    s_wb_stb_i = '0;
    repeat (3) tick();

    chk("pending_expect", 64'(sbq.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
